// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity bit, one stop bit.
// Latency: TXD drops to the start bit on the same edge that accepts TX_START; TX_DONE pulses one cycle after the stop bit ends.
// Backpressure: TX_START is only sampled in IDLE (including the TX_DONE cycle); requests during a frame are ignored.
//
// Ports:
//   CLK        single clock, rising edge
//   RST        asynchronous active-low reset
//   TX_DATA    byte to send, LSB first, latched when the frame starts
//   TX_START   send request, honoured in IDLE only
//   PARITY     parity select (0 = even, 1 = odd), latched with TX_DATA
//   TXD        registered serial line, idle high
//   TX_BUSY    high while a frame is in progress
//   TX_DONE    one-cycle pulse in the first IDLE cycle after the stop bit
//   fsm_state  current FSM state for debug
//
// Build option: define UART_TX_PARITY_EN to add the parity bit (11-bit frame).
// Without it the frame is 10 bits and PARITY is ignored.

module uart_tx #(
  parameter int CLK_FREQ = 125_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] TX_DATA,
  input  logic       TX_START,
  input  logic       PARITY,
  output logic       TXD,
  output logic       TX_BUSY,
  output logic       TX_DONE,
  output logic [2:0] fsm_state
);

  // Cycles per bit, truncating division.
  localparam int BIT_CNT = CLK_FREQ / BAUD;
  localparam int CNT_W   = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CNT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_START = 3'b001,
    S_DATA  = 3'b010,
`ifdef UART_TX_PARITY_EN
    S_PAR   = 3'b011,
`endif
    S_STOP  = 3'b100
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       data_q;
  logic             txd_q, txd_d;
  logic             done_q;
  logic             bit_end;

`ifdef UART_TX_PARITY_EN
  logic             par_q;
  logic             par_bit;

  assign par_bit = (^data_q) ^ par_q;
`else
  logic             unused_parity;

  assign unused_parity = PARITY;
`endif

  assign bit_end = (baud_cnt_q == CNT_LAST);

  // State register plus the datapath registers that follow it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      data_q     <= '0;
      txd_q      <= 1'b1;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      txd_q     <= txd_d;
      done_q    <= (state_q == S_STOP) && (state_d == S_IDLE);

      // Counter restarts on every state change and at every data bit boundary,
      // so it never runs past BIT_CNT-1.
      if ((state_d != state_q) || bit_end) begin
        baud_cnt_q <= '0;
      end else if (state_q != S_IDLE) begin
        baud_cnt_q <= baud_cnt_q + 1'b1;
      end

      if ((state_q == S_IDLE) && TX_START) begin
        data_q <= TX_DATA;
`ifdef UART_TX_PARITY_EN
        par_q  <= PARITY;
`endif
      end
    end
  end

  // Next-state logic, including the data bit index that goes with it.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      S_IDLE: begin
        if (TX_START) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PAR;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PAR: begin
        if (bit_end) begin
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (state_d != S_DATA) begin
      bit_idx_d = 3'd0;
    end
  end

  // Line value for the upcoming state: TXD is registered, so the start bit
  // appears on the very edge that accepts TX_START.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      S_IDLE:  txd_d = 1'b1;
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = data_q[bit_idx_d];
`ifdef UART_TX_PARITY_EN
      S_PAR:   txd_d = par_bit;
`endif
      S_STOP:  txd_d = 1'b1;
      default: txd_d = 1'b1;
    endcase
  end

  assign TXD       = txd_q;
  assign TX_BUSY   = (state_q != S_IDLE);
  assign TX_DONE   = done_q;
  assign fsm_state = state_q;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 125_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, line bit rate in bit/s.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port TX_DATA  input  8  byte to send, LSB first.
REQ-006 SHALL have port TX_START  input  1  request to send TX_DATA.
REQ-007 SHALL have port PARITY  input  1  parity select: 0 = even, 1 = odd.
REQ-008 SHALL have port TXD  output  1  serial line, idle high, registered.
REQ-009 SHALL have port TX_BUSY  output  1  high while a frame is in progress.
REQ-010 SHALL have port TX_DONE  output  1  one-cycle pulse at frame end.
REQ-011 SHALL have port fsm_state  output  3  current FSM state, for debug.

Function
REQ-012 SHALL define bit period BIT_CNT = CLK_FREQ/BAUD, integer division, i.e. 13020 cycles at the defaults.
REQ-013 SHALL hold every frame bit on TXD for exactly BIT_CNT cycles.
REQ-014 SHALL send frames as: start (0), D0..D7, parity (only if enabled, see Configuration), stop (1).
REQ-015 SHALL have FSM states IDLE=000, START=001, DATA=010, PAR=011 and STOP=100, driven onto fsm_state.
REQ-016 SHALL, in IDLE with TX_START=1 at edge k: latch TX_DATA and PARITY, enter START, and drive TXD=0 and TX_BUSY=1 from edge k.
REQ-017 SHALL ignore TX_START, TX_DATA and PARITY outside IDLE; latched values are used for the whole frame.
REQ-018 SHALL move START->DATA after BIT_CNT cycles.
REQ-019 SHALL stay in DATA for 8 bit periods using a 3-bit index that counts 0..7, then move to PAR (parity enabled) or STOP (parity disabled).
REQ-020 SHALL compute the parity bit as XOR-reduction of the latched byte XOR the latched PARITY.
REQ-021 SHALL move PAR->STOP after one bit period.
REQ-022 SHALL, after one stop bit period, enter IDLE, with TX_DONE=1 and TX_BUSY=0 for exactly that first IDLE cycle.
REQ-023 SHALL accept TX_START asserted during the TX_DONE cycle, giving back-to-back frames with no idle gap beyond the stop bit.
REQ-024 SHALL, with TX_START held high continuously, send consecutive identical-format frames, each sampling TX_DATA on its own IDLE cycle.
REQ-025 SHALL reset the baud counter to 0 at each state transition and never let it exceed BIT_CNT-1.

Reset
REQ-026 SHALL, while RST=0, force TXD=1, TX_BUSY=0, TX_DONE=0, fsm_state=IDLE, and counters and latched data to 0, regardless of CLK.
REQ-027 SHALL abort any frame in progress on reset, with TXD returning high immediately and no TX_DONE pulse.
REQ-028 SHALL accept TX_START on the first rising edge after RST deasserts.

Configuration
REQ-029 SHALL, when macro UART_TX_PARITY_EN is defined, include the PAR state and the parity bit, giving an 11-bit frame of 11*BIT_CNT cycles.
REQ-030 SHALL, without UART_TX_PARITY_EN, omit the PAR state and parity logic and ignore PARITY, giving a 10-bit frame of 10*BIT_CNT cycles; fsm_state never shows 011.

Verification
REQ-031 SHALL pass: parity enabled, PARITY=0, TX_DATA=8'hB8, one-cycle TX_START -> TXD = 0,0,0,0,1,1,1,0,1,0,1 at 13020 cycles each, TX_DONE at cycle 143220.
REQ-032 SHALL pass: parity enabled, PARITY=1, TX_DATA=8'h01 -> parity bit = 0, stop bit = 1, TX_BUSY high for exactly 143220 cycles.
REQ-033 SHALL pass: parity disabled, TX_DATA=8'hFF -> start bit 0, 8 ones, stop bit 1; TX_DONE at cycle 130200; fsm_state never 011.
REQ-034 SHALL pass: TX_START held high, TX_DATA changed to 8'h55 mid-frame -> first frame carries the original byte, second frame carries 8'h55 and starts in the TX_DONE cycle.
REQ-035 SHALL pass: RST pulled low during DATA bit 3 -> TXD=1, TX_BUSY=0, fsm_state=000 immediately, no TX_DONE; a new TX_START after release sends a full correct frame.
REQ-036 SHALL pass: a self-check loopback of TXD into a uart_rx instance with matching PARITY -> RX_DATA equals TX_DATA and RX_DATA_RDY pulses for each frame.
